seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL have localparam CW, equal to $clog2(WIDTH)+1, giving the multiply cycle-counter width.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Ain  input  WIDTH  operand A.
REQ-008 Bin  input  WIDTH  operand B.
REQ-009 ALUop  input  3  operation select.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out  output  WIDTH  registered result.
REQ-013 N, V, Z  output  1 each  registered negative, overflow and zero flags.

Function
REQ-014 ALUop encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT (~Bin), 100 OR, 101 XOR, 110 SHL, 111 MUL.
REQ-015 SHL SHALL shift Ain left logically by Bin[$clog2(WIDTH)-1:0] bits and ignore the upper bits of Bin.
REQ-016 MUL SHALL be an unsigned iterative shift-add over WIDTH cycles; out SHALL be the low WIDTH bits of the 2*WIDTH-bit product.
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE with in_valid=1 SHALL be an accept: operands and ALUop are latched, then the FSM moves to BUSY if ALUop=MUL and to DONE otherwise.
REQ-019 For non-MUL operations, out, N, V and Z SHALL be registered on the accept edge, so out_valid=1 in the cycle after the accept.
REQ-020 BUSY SHALL run exactly WIDTH iterations, using a CW-bit counter cleared on accept; after the final iteration the FSM SHALL go to DONE, so out_valid=1 WIDTH+1 cycles after the accept.
REQ-021 out_valid SHALL equal (state==DONE); out, N, V and Z SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 DONE with out_ready=1 SHALL return the FSM to IDLE on the next edge; there is no same-cycle re-accept, so the maximum throughput is one op per two cycles.
REQ-023 N SHALL equal out[WIDTH-1], and Z SHALL equal (out==0), for all operations.
REQ-024 V for ADD SHALL be 1 when Ain and Bin have the same sign and the result sign differs from Ain's sign.
REQ-025 V for SUB SHALL be 1 when Ain and Bin have different signs and the result sign differs from Ain's sign.
REQ-026 V for MUL SHALL be 1 when the upper WIDTH bits of the product are nonzero.
REQ-027 V SHALL be 0 for AND, NOT, OR, XOR and SHL.
REQ-028 Ain, Bin and ALUop SHALL be ignored whenever in_ready=0.
REQ-029 in_valid asserted in BUSY or DONE SHALL be neither accepted nor lost-state-corrupting; the source SHALL hold it until in_ready=1.

Reset
REQ-030 reset=1 at a clock edge SHALL force state to IDLE and clear out, N, V, Z, the counter and the product accumulator to 0, so that in_ready=1 and out_valid=0 in the next cycle.
REQ-031 reset SHALL take priority over any accept, iteration or handoff in the same cycle.
REQ-032 A reset asserted mid-BUSY SHALL discard the partial product and produce no out_valid pulse.

Structure
REQ-033 The ALUop encodings and the FSM state encodings SHALL live in a shared package, seq_alu_pkg.
REQ-034 The combinational ADD/SUB/AND/NOT/OR/XOR/SHL datapath and its flag logic SHALL be one sub-module, alu_core, parametrised by WIDTH.
REQ-035 The FSM, the multiply iteration and the output registers SHALL reside in seq_alu.

Verification
REQ-036 With WIDTH=16, ADD Ain=0x7FFF, Bin=0x0001 SHALL give out=0x8000, N=1, V=1, Z=0, with out_valid high 1 cycle after the accept.
REQ-037 SUB Ain=0x0005, Bin=0x0005 SHALL give out=0x0000, Z=1, N=0, V=0; SUB Ain=0x8000, Bin=0x0001 SHALL give out=0x7FFF, V=1.
REQ-038 MUL Ain=0x0100, Bin=0x0100 SHALL give out=0x0000, V=1, Z=1 at cycle 17 after the accept; MUL 0x00FF*0x0003 SHALL give out=0x02FD, V=0.
REQ-039 Backpressure: with out_ready=0 for 5 cycles after a NOT of Bin=0x00F0, out SHALL hold 0xFF0F with N=1, in_ready SHALL be 0 throughout, and the FSM SHALL return to IDLE the edge after out_ready=1.
REQ-040 A reset pulsed at cycle 8 of a MUL SHALL give in_ready=1 and out_valid=0 next cycle with all outputs 0, and a following ADD 2+3 SHALL give out=0x0005.
REQ-041 SHL Ain=0x0001, Bin=0x0013 SHALL shift by 3 and give out=0x0008, V=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_alu_alu_core.sv
// Single-cycle combinational datapath for every operation except MUL, plus its N/V/Z flags.
module alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             v,
    output logic             z
);

    localparam int SW = $clog2(WIDTH);

    always_comb begin
        result = '0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = a + b;
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = a - b;
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_NOT: result = ~b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            // Only the low shift-amount bits of b matter; upper bits are ignored.
            OP_SHL: result = a << b[SW-1:0];
            default: result = '0;
        endcase
        n = result[WIDTH-1];
        z = (result == '0);
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: one operand set at a time, single-cycle ops via alu_core, MUL by iterative shift-add.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             V,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e              state;
    state_e              next_state;
    alu_op_e             op_in;
    logic                is_mul;
    logic                last_iter;
    logic [WIDTH-1:0]    core_result;
    logic                core_n;
    logic                core_v;
    logic                core_z;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_next;
    logic [2*WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]    mplier;
    logic [CW-1:0]       cnt;

    assign op_in     = alu_op_e'(ALUop);
    assign is_mul    = (op_in == OP_MUL);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (Ain),
        .b      (Bin),
        .op     (op_in),
        .result (core_result),
        .n      (core_n),
        .v      (core_v),
        .z      (core_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = is_mul ? S_BUSY : S_DONE;
            S_BUSY:  if (last_iter) next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Multiplier iteration and result registers; outputs only change on accept or the final MUL step.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            out    <= '0;
            N      <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, Ain};
                        mplier <= Bin;
                        cnt    <= '0;
                        if (!is_mul) begin
                            out <= core_result;
                            N   <= core_n;
                            V   <= core_v;
                            Z   <= core_z;
                        end
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        out <= acc_next[WIDTH-1:0];
                        N   <= acc_next[WIDTH-1];
                        V   <= |acc_next[2*WIDTH-1:WIDTH];
                        Z   <= (acc_next[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at accept, compared while out_valid is high.
module tb_seq_alu;

    localparam int W = 16;

    typedef struct {
        string       name;
        logic [W-1:0] out;
        logic        n;
        logic        v;
        logic        z;
        int          lat;
        int          acc_cycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] Ain = '0;
    logic [W-1:0] Bin = '0;
    logic [2:0]   ALUop = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         N;
    logic         V;
    logic         Z;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   rand_bp = 1'b0;
    bit   front_seen = 1'b0;
    exp_t sb[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .N         (N),
        .V         (V),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic string op_name(input logic [2:0] op);
        case (op)
            3'd0: return "add";
            3'd1: return "sub";
            3'd2: return "and";
            3'd3: return "not";
            3'd4: return "or";
            3'd5: return "xor";
            3'd6: return "shl";
            default: return "mul";
        endcase
    endfunction

    // Reference model: plain arithmetic on the operands, full-width product for MUL.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [2*W-1:0] p;
        e.name = op_name(op);
        e.v    = 1'b0;
        e.lat  = 1;
        e.out  = '0;
        case (op)
            3'd0: begin
                e.out = a + b;
                e.v   = (a[W-1] == b[W-1]) && (e.out[W-1] != a[W-1]);
            end
            3'd1: begin
                e.out = a - b;
                e.v   = (a[W-1] != b[W-1]) && (e.out[W-1] != a[W-1]);
            end
            3'd2: e.out = a & b;
            3'd3: e.out = ~b;
            3'd4: e.out = a | b;
            3'd5: e.out = a ^ b;
            3'd6: e.out = a << (b % W);
            default: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.out = p[W-1:0];
                e.v   = (p[2*W-1:W] != '0);
                e.lat = W + 1;
            end
        endcase
        e.n = e.out[W-1];
        e.z = (e.out == '0);
        e.acc_cycle = 0;
        return e;
    endfunction

    // Monitor: compare the head entry every cycle out_valid is high, pop on handshake, push on accept.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            front_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = sb[0];
                    if (!front_seen) begin
                        checkOutput({e.name, "_latency"}, 64'(cycle - e.acc_cycle), 64'(e.lat));
                        front_seen = 1'b1;
                    end
                    checkOutput({e.name, "_out"}, 64'(out), 64'(e.out));
                    checkOutput({e.name, "_N"}, 64'(N), 64'(e.n));
                    checkOutput({e.name, "_V"}, 64'(V), 64'(e.v));
                    checkOutput({e.name, "_Z"}, 64'(Z), 64'(e.z));
                    checkOutput("in_ready_while_done", 64'(in_ready), 64'(0));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(ALUop, Ain, Bin);
                e.acc_cycle = cycle;
                sb.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit accepted = 1'b0;
        int guard = 0;
        ALUop    = op;
        Ain      = a;
        Bin      = b;
        in_valid = 1'b1;
        while (!accepted && guard < 200) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
        Ain      = W'($urandom);
        Bin      = W'($urandom);
        ALUop    = 3'($urandom);
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 300) checkOutput("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_out", 64'(out), 64'(0));
        checkOutput("reset_flags", 64'({N, V, Z}), 64'(0));

        applyStimulus(3'd0, 16'h7FFF, 16'h0001);
        waitDrain();
        applyStimulus(3'd1, 16'h0005, 16'h0005);
        applyStimulus(3'd1, 16'h8000, 16'h0001);
        applyStimulus(3'd7, 16'h0100, 16'h0100);
        applyStimulus(3'd7, 16'h00FF, 16'h0003);
        applyStimulus(3'd6, 16'h0001, 16'h0013);
        applyStimulus(3'd2, 16'hF0F0, 16'h3C3C);
        applyStimulus(3'd4, 16'hF0F0, 16'h0F0F);
        applyStimulus(3'd5, 16'hFFFF, 16'hFFFF);
        waitDrain();

        $display("[TB] backpressure on NOT");
        out_ready = 1'b0;
        applyStimulus(3'd3, 16'h1234, 16'h00F0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_out", 64'(out), 64'(16'hFF0F));
            checkOutput("bp_N", 64'(N), 64'(1));
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle_in_ready", 64'(in_ready), 64'(1));
        checkOutput("bp_idle_out_valid", 64'(out_valid), 64'(0));

        $display("[TB] reset in the middle of a multiply");
        applyStimulus(3'd7, 16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midreset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midreset_out", 64'(out), 64'(0));
        checkOutput("midreset_flags", 64'({N, V, Z}), 64'(0));
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midreset_no_result", 64'(out_valid), 64'(0));
        applyStimulus(3'd0, 16'h0002, 16'h0003);
        waitDrain();
        checkOutput("post_reset_add", 64'(out), 64'(16'h0005));

        $display("[TB] random operations with random backpressure");
        rand_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        checkOutput("final_idle", 64'(in_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
